mac_acc_4b: RTL and testbench

Multiply-accumulate back end for the 4-bit multiplier family (ma_mul_4b, csa_mul_4b, mul_4x4). It consumes the 8-bit product these multipliers produce, one beat per handshake, and sums TERMS consecutive products into a dot-product result. The result is presented on a valid/ready output port, together with a sticky overflow flag. It sits directly downstream of the combinational multiplier and registers every output.

---
 rtl/mac_acc_4b.sv | 80 ++++++++
 tb/tb_mac_acc_4b.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mac_acc_4b.sv
// mac_acc_4b: sums TERMS consecutive 8-bit products into one valid/ready result with a sticky overflow flag.
module mac_acc_4b #(
  parameter int ACC_W = 12,
  parameter int TERMS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [7:0]       in_prod_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [ACC_W-1:0] out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_ovf_o,
  output logic             busy_o
);
  localparam int CNT_W = $clog2(TERMS + 1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  logic [ACC_W:0]   sum;
  logic             accept, last;
  always_comb begin
    sum       = {1'b0, acc_q} + (ACC_W + 1)'(in_prod_i);
    accept    = in_valid_i & (state_q == ACCUM);
    last      = cnt_q == CNT_W'(TERMS - 1);
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_d     = out_q;
    out_ovf_d = out_ovf_q;
    // clr drops any beat offered in the same cycle but leaves out untouched
    if (clr_i) begin
      state_d   = ACCUM;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      out_ovf_d = 1'b0;
    end else if (accept) begin
      acc_d = last ? '0 : sum[ACC_W-1:0];
      cnt_d = last ? '0 : cnt_q + 1'b1;
      ovf_d = ovf_q | sum[ACC_W];
      if (last) begin
        out_d     = sum[ACC_W-1:0];
        out_ovf_d = ovf_q | sum[ACC_W];
        state_d   = HOLD;
      end
    end else if (state_q == HOLD && out_ready_i) begin
      state_d   = ACCUM;
      ovf_d     = 1'b0;
      out_ovf_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  assign in_ready_o  = state_q == ACCUM;
  assign out_valid_o = state_q == HOLD;
  assign out_o       = out_q;
  assign out_ovf_o   = out_ovf_q;
  assign busy_o      = (cnt_q != '0) | (state_q == HOLD);
endmodule

// File: tb/tb_mac_acc_4b.sv
// tb_mac_acc_4b: scoreboard bench running a 12-bit and an 8-bit accumulator side by side on shared stimulus.
module tb_mac_acc_4b;
  logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_prod = '0;
  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [11:0] out_a;
  logic [7:0]  out_b;
  typedef struct {int o12; int v12; int o8; int v8;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;
  int a12 = 0, a8 = 0, f12 = 0, f8 = 0, cnt = 0;

  always #5 clk = ~clk;

  mac_acc_4b #(.ACC_W(12), .TERMS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .in_prod_i(in_prod), .in_valid_i(in_valid),
    .in_ready_o(in_ready_a), .out_o(out_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .out_ovf_o(out_ovf_a), .busy_o(busy_a));
  mac_acc_4b #(.ACC_W(8), .TERMS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .in_prod_i(in_prod), .in_valid_i(in_valid),
    .in_ready_o(in_ready_b), .out_o(out_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .out_ovf_o(out_ovf_b), .busy_o(busy_b));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    a12 = 0; a8 = 0; f12 = 0; f8 = 0; cnt = 0;
  endtask

  task automatic m_beat(input int p);
    a12 += p;
    if (a12 > 4095) begin a12 -= 4096; f12 = 1; end
    a8 += p;
    if (a8 > 255) begin a8 -= 256; f8 = 1; end
    cnt++;
    if (cnt == 4) begin
      sb.push_back('{a12, f12, a8, f8});
      m_clear();
    end
  endtask

  task automatic send(input int p);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_prod = 8'(p);
    while (!in_ready_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) chk("in_ready_timeout", 0, 1);
    m_beat(p);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out12", int'(out_a), e.o12);
        chk("ovf12", int'(out_ovf_a), e.v12);
        chk("out8", int'(out_b), e.o8);
        chk("ovf8", int'(out_ovf_b), e.v8);
        chk("valid8", int'(out_valid_b), 1);
      end
    end
  end

  initial begin
    #3;
    chk("rst_valid", out_valid_a, 0);
    chk("rst_out", out_a, 0);
    chk("rst_ovf", out_ovf_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_busy", busy_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(3); send(5); send(7); send(9);
    idle();
    chk("hold_in_ready", in_ready_a, 0);
    chk("hold_valid", out_valid_a, 1);
    chk("hold_busy", busy_a, 1);
    @(posedge clk); #1;
    chk("valid_one_cycle", out_valid_a, 0);
    chk("idle_busy", busy_a, 0);
    drain();
    for (int i = 0; i < 256; i++) send((i >> 4) * (i & 15));
    idle();
    drain();
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    @(posedge clk); #1;
    in_prod = 8'd77;
    for (int k = 0; k < 6; k++) begin
      chk("bp_valid", out_valid_a, 1);
      chk("bp_out", out_a, 10);
      chk("bp_in_ready", in_ready_a, 0);
      if (k < 5) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    send(5); send(5); send(5); send(5);
    idle();
    drain();
    send(200); send(100); send(1); send(1);
    send(1); send(1); send(1); send(1);
    idle();
    drain();
    send(10); send(20);
    @(posedge clk); #1;
    clr = 1'b1;
    in_valid = 1'b1;
    in_prod = 8'd99;
    m_clear();
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", busy_a, 0);
    chk("clr_busy8", busy_b, 0);
    send(1); send(2); send(3); send(4);
    idle();
    drain();
    out_ready = 1'b0;
    send(200); send(100); send(1); send(1);
    idle();
    chk("pre_rst_valid", out_valid_a, 1);
    chk("pre_rst_ovf8", out_ovf_b, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid_a, 0);
    chk("arst_out", out_a, 0);
    chk("arst_out8", out_b, 0);
    chk("arst_ovf8", out_ovf_b, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_in_ready", in_ready_a, 1);
    sb.delete();
    m_clear();
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1); send(1); send(1); send(1);
    idle();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
